// File: rtl/line_test_scheduler.sv
// line_test_scheduler: shares one combinational pixel_on_line tester across a table of line descriptors.
// Optional LINE_SCHED_EARLY_EXIT_EN: the scan ends on the first enabled hit instead of walking the whole table.
module line_test_scheduler #(
    parameter int NUM_LINES = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_LINES)-1:0]   cfg_idx,
    input  logic                           cfg_en,
    input  logic signed [31:0]             cfg_x0,
    input  logic signed [31:0]             cfg_y0,
    input  logic signed [31:0]             cfg_xn,
    input  logic signed [31:0]             cfg_yn,
    input  logic signed [31:0]             cfg_mag,
    output logic                           cfg_busy,
    input  logic                           q_valid,
    output logic                           q_ready,
    input  logic signed [31:0]             q_x,
    input  logic signed [31:0]             q_y,
    output logic                           r_valid,
    input  logic                           r_ready,
    output logic                           r_hit,
    output logic [$clog2(NUM_LINES)-1:0]   r_idx,
    output logic signed [31:0]             dp_x,
    output logic signed [31:0]             dp_y,
    output logic signed [31:0]             dp_x0,
    output logic signed [31:0]             dp_y0,
    output logic signed [31:0]             dp_xn,
    output logic signed [31:0]             dp_yn,
    output logic signed [31:0]             dp_mag,
    input  logic                           dp_on_line
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state;

    logic [NUM_LINES-1:0] tbl_en;
    logic signed [31:0]   tbl_x0  [NUM_LINES];
    logic signed [31:0]   tbl_y0  [NUM_LINES];
    logic signed [31:0]   tbl_xn  [NUM_LINES];
    logic signed [31:0]   tbl_yn  [NUM_LINES];
    logic signed [31:0]   tbl_mag [NUM_LINES];

    logic [IDX_W-1:0]   idx;
    logic signed [31:0] qx_q;
    logic signed [31:0] qy_q;
    logic               hit_now;
    logic               stop_scan;

    assign hit_now = dp_on_line & tbl_en[idx];

`ifdef LINE_SCHED_EARLY_EXIT_EN
    assign stop_scan = (idx == LAST_IDX) | hit_now;
`else
    assign stop_scan = (idx == LAST_IDX);
`endif

    // The tester sees the latched query and whichever entry idx currently selects.
    assign dp_x   = qx_q;
    assign dp_y   = qy_q;
    assign dp_x0  = tbl_x0[idx];
    assign dp_y0  = tbl_y0[idx];
    assign dp_xn  = tbl_xn[idx];
    assign dp_yn  = tbl_yn[idx];
    assign dp_mag = tbl_mag[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            qx_q     <= '0;
            qy_q     <= '0;
            q_ready  <= 1'b1;
            cfg_busy <= 1'b0;
            r_valid  <= 1'b0;
            r_hit    <= 1'b0;
            r_idx    <= '0;
            tbl_en   <= '0;
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                tbl_x0[i]  <= '0;
                tbl_y0[i]  <= '0;
                tbl_xn[i]  <= '0;
                tbl_yn[i]  <= '0;
                tbl_mag[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A write coincident with an accept lands before idx 0 is read, so the scan sees it.
                    if (cfg_we && (int'(cfg_idx) < NUM_LINES)) begin
                        tbl_en[cfg_idx]  <= cfg_en;
                        tbl_x0[cfg_idx]  <= cfg_x0;
                        tbl_y0[cfg_idx]  <= cfg_y0;
                        tbl_xn[cfg_idx]  <= cfg_xn;
                        tbl_yn[cfg_idx]  <= cfg_yn;
                        tbl_mag[cfg_idx] <= cfg_mag;
                    end
                    if (q_valid) begin
                        qx_q     <= q_x;
                        qy_q     <= q_y;
                        idx      <= '0;
                        r_hit    <= 1'b0;
                        r_idx    <= '0;
                        q_ready  <= 1'b0;
                        cfg_busy <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit_now && !r_hit) begin
                        r_hit <= 1'b1;
                        r_idx <= idx;
                    end
                    if (stop_scan) begin
                        r_valid <= 1'b1;
                        state   <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (r_ready) begin
                        r_valid  <= 1'b0;
                        q_ready  <= 1'b1;
                        cfg_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
